// File: rtl/conv_ctrl_pkg.sv
// Shared widths and FSM state encodings for the convolution frame controller.
package conv_ctrl_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned FRAMECNT_W = 16;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_FEED,
    IN_FLUSH,
    IN_WAIT
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_SKIP,
    OUT_PASS,
    OUT_TAIL
  } out_state_t;

endpackage

// File: rtl/conv_ctrl_watchdog.sv
// Idle-cycle watchdog: counts busy cycles with no stream activity and raises a
// one-cycle expire strobe plus a sticky error flag on reaching the limit.
module conv_ctrl_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic activity_i,
  output logic expire_c_o,
  output logic err_o
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_q, err_d;

  // Expire fires on the cycle that would make the idle run TIMEOUT_CYCLES long.
  always_comb begin
    idle_d     = idle_q;
    err_d      = err_q;
    expire_c_o = 1'b0;
    if (!busy_i || activity_i) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d     = '0;
      expire_c_o = 1'b1;
      err_d      = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer around the serializer/convolution/deserializer pipeline.
// Optional watchdog enabled by defining CONV_FRAME_CTRL_TIMEOUT_EN.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_WORDS    = 1024,
  parameter int unsigned FLUSH_WORDS    = 4,
  parameter int unsigned DROP_WORDS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [FRAMECNT_W-1:0] frames_done,
  output logic                  err,
  input  logic [WORD_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [WORD_W-1:0]     p_data,
  output logic                  p_valid,
  input  logic                  p_ready,
  input  logic [WORD_W-1:0]     q_data,
  input  logic                  q_valid,
  output logic                  q_ready,
  output logic [WORD_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int unsigned CNT_W      = $clog2(FRAME_WORDS + FLUSH_WORDS + 1);
  localparam int unsigned TAIL_WORDS = FLUSH_WORDS - DROP_WORDS;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_WORDS - 1);
  localparam logic [CNT_W-1:0] DROP_LAST  = CNT_W'(DROP_WORDS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_WORDS - 1);

  // Reject parameter sets the sequencing cannot honour.
  if (FRAME_WORDS < 1) begin : g_chk_frame
    $error("conv_frame_ctrl: FRAME_WORDS must be at least 1");
  end
  if (DROP_WORDS > FLUSH_WORDS) begin : g_chk_drop
    $error("conv_frame_ctrl: DROP_WORDS must not exceed FLUSH_WORDS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("conv_frame_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  in_state_t              in_state_q, in_state_d;
  out_state_t             out_state_q, out_state_d;
  logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [FRAMECNT_W-1:0]  frames_q, frames_d;
  logic                   complete_c;
  logic                   abort_c;
  logic                   p_hs_c;
  logic                   q_hs_c;
  logic                   activity_c;

  // Handshakes derived from state and inputs only, keeping the watchdog loop-free.
  assign p_hs_c = ((in_state_q == IN_FEED) && s_valid && p_ready) ||
                  ((in_state_q == IN_FLUSH) && p_ready);
  assign q_hs_c = q_valid &&
                  ((out_state_q == OUT_SKIP) || (out_state_q == OUT_TAIL) ||
                   ((out_state_q == OUT_PASS) && m_ready));
  assign activity_c = p_hs_c || q_hs_c;

`ifdef CONV_FRAME_CTRL_TIMEOUT_EN
  conv_ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .busy_i    (busy_q),
    .activity_i(activity_c),
    .expire_c_o(abort_c),
    .err_o     (err)
  );
`else
  assign abort_c = 1'b0;
  assign err     = 1'b0;
`endif

  // Zero-latency stream steering selected by the two FSM states.
  always_comb begin
    s_ready = 1'b0;
    p_valid = 1'b0;
    p_data  = '0;
    q_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    case (in_state_q)
      IN_FEED: begin
        p_data  = s_data;
        p_valid = s_valid;
        s_ready = p_ready;
      end
      IN_FLUSH: p_valid = 1'b1;
      default: ;
    endcase
    case (out_state_q)
      OUT_SKIP, OUT_TAIL: q_ready = 1'b1;
      OUT_PASS: begin
        m_data  = q_data;
        m_valid = q_valid;
        q_ready = m_ready;
      end
      default: ;
    endcase
  end

  // Next-state logic for both FSMs, frame completion and watchdog abort.
  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frames_d    = frames_q;
    complete_c  = 1'b0;

    case (in_state_q)
      IN_IDLE: begin
        if (start) begin
          in_state_d  = IN_FEED;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          busy_d      = 1'b1;
          out_state_d = (DROP_WORDS == 0) ? OUT_PASS : OUT_SKIP;
        end
      end
      IN_FEED: begin
        if (p_hs_c) begin
          if (in_cnt_q == FRAME_LAST) begin
            in_cnt_d   = '0;
            in_state_d = (FLUSH_WORDS == 0) ? IN_WAIT : IN_FLUSH;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      IN_FLUSH: begin
        if (p_hs_c) begin
          if (in_cnt_q == FLUSH_LAST) begin
            in_cnt_d   = '0;
            in_state_d = IN_WAIT;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    case (out_state_q)
      OUT_SKIP: begin
        if (q_hs_c) begin
          if (out_cnt_q == DROP_LAST) begin
            out_cnt_d   = '0;
            out_state_d = OUT_PASS;
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
      end
      OUT_PASS: begin
        if (q_hs_c) begin
          if (out_cnt_q == FRAME_LAST) begin
            out_cnt_d = '0;
            if (TAIL_WORDS == 0) begin
              complete_c = 1'b1;
            end else begin
              out_state_d = OUT_TAIL;
            end
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
      end
      OUT_TAIL: begin
        if (q_hs_c) begin
          if (out_cnt_q == TAIL_LAST) begin
            complete_c = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Completion and abort both return everything to idle; only completion counts.
    if (complete_c || abort_c) begin
      in_state_d  = IN_IDLE;
      out_state_d = OUT_IDLE;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      busy_d      = 1'b0;
    end
    if (complete_c && !abort_c) begin
      done_d   = 1'b1;
      frames_d = frames_q + FRAMECNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frames_q    <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frames_q    <= frames_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: randomized host/sink traffic around a
// queue-based pipeline model with two warm-up words, plus a zero-flush instance.
module tb_conv_frame_ctrl;

  localparam int unsigned FW = 8;
  localparam int unsigned FL = 2;
  localparam int unsigned DR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: FRAME 8, FLUSH 2, DROP 2
  logic        start, busy, done, err;
  logic [15:0] frames_done;
  logic [63:0] s_data, p_data, q_data, m_data;
  logic        s_valid, s_ready, p_valid, p_ready, q_valid, q_ready, m_valid, m_ready;

  conv_frame_ctrl #(
    .FRAME_WORDS(FW), .FLUSH_WORDS(FL), .DROP_WORDS(DR), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .frames_done(frames_done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  // Instance B: FRAME 8, FLUSH 0, DROP 0, pipeline is a plain wire
  logic        b_start, b_busy, b_done, b_err;
  logic [15:0] b_frames_done;
  logic [63:0] b_s_data, b_p_data, b_q_data, b_m_data;
  logic        b_s_valid, b_s_ready, b_p_valid, b_p_ready, b_q_valid, b_q_ready, b_m_valid, b_m_ready;

  assign b_q_data  = b_p_data;
  assign b_q_valid = b_p_valid;
  assign b_p_ready = b_q_ready;

  conv_frame_ctrl #(
    .FRAME_WORDS(FW), .FLUSH_WORDS(0), .DROP_WORDS(0), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .frames_done(b_frames_done), .err(b_err),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .p_data(b_p_data), .p_valid(b_p_valid), .p_ready(b_p_ready),
    .q_data(b_q_data), .q_valid(b_q_valid), .q_ready(b_q_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  logic [63:0] host_q[$];
  logic [63:0] pipe_q[$];
  logic [63:0] exp_m[$];
  logic [63:0] exp_p[$];
  bit          thr, host_en, hold_q;
  bit          s_fire_r, p_fire_r, q_fire_r;
  logic [63:0] p_data_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle the handshakes that fire on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      s_fire_r = 1'b0;
      p_fire_r = 1'b0;
      q_fire_r = 1'b0;
    end else begin
      s_fire_r = s_valid && s_ready;
      p_fire_r = p_valid && p_ready;
      q_fire_r = q_valid && q_ready;
      p_data_r = p_data;
      if (!busy) check("idle_blocked", {s_ready, p_valid, q_ready, m_valid}, 4'b0);
      if (done) done_cnt++;
      if (p_fire_r) begin
        check("p_pending", exp_p.size() > 0, 1);
        if (exp_p.size() > 0) check("p_data", p_data, exp_p.pop_front());
      end
      if (m_valid && m_ready) begin
        check("m_pending", exp_m.size() > 0, 1);
        if (exp_m.size() > 0) check("m_data", m_data, exp_m.pop_front());
      end
    end
  end

  // Host source, pipeline model and sink throttle for instance A.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (s_fire_r) void'(host_q.pop_front());
      if (p_fire_r) pipe_q.push_back(p_data_r);
      if (q_fire_r) void'(pipe_q.pop_front());
      s_valid = host_en && (host_q.size() > 0) && (!thr || ($urandom_range(1) == 1));
      s_data  = (host_q.size() > 0) ? host_q[0] : 64'd0;
      p_ready = pipe_q.size() < 8;
      q_valid = !hold_q && (pipe_q.size() > 0);
      q_data  = (pipe_q.size() > 0) ? pipe_q[0] : 64'd0;
      m_ready = !thr || ($urandom_range(1) == 1);
    end
  end

  task automatic prep_frame();
    logic [63:0] w;
    host_q.delete();
    for (int i = 0; i < FW; i++) begin
      w = {$urandom, $urandom};
      host_q.push_back(w);
      exp_m.push_back(w);
      exp_p.push_back(w);
    end
    for (int i = 0; i < FL; i++) exp_p.push_back(64'd0);
    host_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic end_checks(input string tag, input int exp_fd);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_frames_done"}, frames_done, 64'(exp_fd));
    check({tag, "_surplus_held"}, host_q.size(), 1);
    check({tag, "_m_drained"}, exp_m.size(), 0);
    check({tag, "_p_drained"}, exp_p.size(), 0);
  endtask

  task automatic run_frame(input string tag, input bit throttle, input int exp_fd);
    int dc0;
    @(negedge clk);
    prep_frame();
    thr = throttle;
    host_en = 1'b1;
    dc0 = done_cnt;
    pulse_start();
    wait_done(tag);
    end_checks(tag, exp_fd);
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, done_cnt - dc0, 1);
  endtask

  initial begin
    int dc0;
    rst = 1'b1; start = 1'b0; thr = 1'b0; host_en = 1'b0; hold_q = 1'b0;
    s_valid = 1'b0; s_data = '0; p_ready = 1'b0; q_valid = 1'b0; q_data = '0; m_ready = 1'b0;
    b_start = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
    pipe_q = {64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002};
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ctrl", {busy, done, err}, 3'b0);
    check("rst_a_frames", frames_done, 0);
    check("rst_a_streams", {s_ready, p_valid, q_ready, m_valid}, 4'b0);
    check("rst_b_all", {b_busy, b_done, b_err, b_s_ready, b_p_valid, b_q_ready, b_m_valid}, 7'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: unthrottled frame
    run_frame("t1", 1'b0, 1);
    // 2: randomly throttled frames
    run_frame("t2a", 1'b1, 2);
    run_frame("t2b", 1'b1, 3);

    // 3: start while busy is ignored, start in the done cycle is accepted
    @(negedge clk);
    prep_frame();
    thr = 1'b1;
    dc0 = done_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t3a");
    end_checks("t3a", 4);
    prep_frame();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t3_busy_after_done_start", busy, 1'b1);
    wait_done("t3b");
    end_checks("t3b", 5);
    repeat (3) @(negedge clk);
    check("t3_done_twice", done_cnt - dc0, 2);

    // 4: asynchronous reset mid-frame
    @(negedge clk);
    prep_frame();
    thr = 1'b0;
    pulse_start();
    for (int i = 0; i < 500 && host_q.size() > 4; i++) @(negedge clk);
    check("t4_five_accepted", host_q.size(), 4);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_ctrl", {busy, done, err}, 3'b0);
    check("t4_rst_frames", frames_done, 0);
    check("t4_rst_streams", {s_ready, p_valid, q_ready, m_valid}, 4'b0);
    @(posedge clk);
    @(negedge clk);
    host_q.delete(); exp_m.delete(); exp_p.delete();
    pipe_q = {64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0004};
    rst = 1'b0;
    run_frame("t4", 1'b1, 1);

    // 5: no flush, no drop, pipeline as a wire
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("t5_busy", b_busy, 1'b1);
    for (int i = 1; i <= FW; i++) begin
      b_s_data  = 64'(i) * 64'h0101_0101;
      b_s_valid = 1'b1;
      @(negedge clk);
      check("t5_s_ready", b_s_ready, 1'b1);
      check("t5_m_valid", b_m_valid, 1'b1);
      check("t5_m_data", b_m_data, 64'(i) * 64'h0101_0101);
      check("t5_no_early_done", b_done, 1'b0);
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    @(negedge clk);
    check("t5_done", b_done, 1'b1);
    check("t5_frames", b_frames_done, 1);
    check("t5_busy_low", b_busy, 1'b0);

`ifdef CONV_FRAME_CTRL_TIMEOUT_EN
    // 6: stall q mid-frame until the watchdog aborts
    begin
      logic [15:0] fd0;
      bit          got_err = 1'b0;
      @(negedge clk);
      prep_frame();
      thr = 1'b0;
      fd0 = frames_done;
      dc0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 200 && exp_m.size() > 4; i++) @(negedge clk);
      hold_q = 1'b1;
      for (int i = 0; i < 200 && !got_err; i++) begin
        @(negedge clk);
        got_err = err;
      end
      check("t6_err", got_err, 1'b1);
      check("t6_busy_low", busy, 1'b0);
      check("t6_frames_kept", frames_done, 64'(fd0));
      repeat (5) @(negedge clk);
      check("t6_no_done", done_cnt - dc0, 0);
      check("t6_err_sticky", err, 1'b1);
      hold_q = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
